// File: rtl/fpu_pkg.sv
// Shared types and constants for the multicycle single-precision FPU.
// Holds the FSM state enum, opcode encodings, IEEE-754 constants and the
// unpacked operand payload that is carried between pipeline states.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    EXEC,
    NORM,
    DONE
  } fpu_state_t;

  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_MUL = 1'b1;

  localparam int unsigned FPU_BIAS    = 127;
  localparam logic [7:0]  FPU_EXP_MAX = 8'hFF;
  localparam logic [31:0] FPU_QNAN    = 32'h7FC00000;

  // 24-bit significand plus guard/round/sticky; 28 bits adds the carry bit
  localparam int unsigned SIG_W  = 27;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned NSIG_W = 28;
  localparam int unsigned LZ_W   = 5;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fpu_unpacked_t;

  // Extended significand with hidden one; exp==0 is flushed to zero
  function automatic logic [SIG_W-1:0] fpu_ext_sig(input logic [31:0] f);
    if (f[30:23] == 8'd0) return '0;
    return {1'b1, f[22:0], 3'b000};
  endfunction

endpackage

// File: rtl/fpu_norm.sv
// Leading-one detect and left shift of a 28-bit significand.
// Ports:
//   sig_i  : significand to normalize (bit 27 is the carry position)
//   lz_o   : number of leading zeros above the first set bit
//   norm_o : sig_i shifted left by lz_o so bit 27 is set (0 if sig_i==0)
module fpu_norm
  import fpu_pkg::*;
(
  input  logic [NSIG_W-1:0] sig_i,
  output logic [LZ_W-1:0]   lz_o,
  output logic [NSIG_W-1:0] norm_o
);

  // Ascending scan: the highest set bit is the last one to write lz_o
  always_comb begin
    lz_o = '0;
    for (int i = 0; i < NSIG_W; i++) begin
      if (sig_i[i]) lz_o = LZ_W'(NSIG_W - 1 - i);
    end
    norm_o = sig_i << lz_o;
  end

endmodule

// File: rtl/fpu_unit.sv
// Multicycle single-precision add/multiply unit with fixed latency.
// A start accepted at edge k produces a one-cycle done after edge k+4.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, op, a, b : request strobe, 0=add 1=mul, IEEE-754 operands
//   result, flags   : packed result and {N,Z}, updated with done and held
//   done, busy      : completion pulse, busy from after start through done
// Parameter LAT_CHECK enables a simulation-only start-to-done latency check.
// Macro FPU_ROUND_NEAREST_EN selects round-to-nearest-even; default truncates.
module fpu_unit
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic [1:0]  flags
);

  fpu_state_t state_q;
  logic [31:0] result_q;
  logic [1:0]  flags_q;
  logic        done_q;
  logic        busy_q;

  logic        op_q;
  logic [31:0] a_q, b_q;
  fpu_unpacked_t x_q, y_q, x_d, y_d;
  logic        byp_q, byp_d;
  logic [31:0] byp_val_q, byp_val_d;
  logic [NSIG_W-1:0] sig_q, sig_e_d;
  logic [EXP_W-1:0]  exp_q, exp_e_d;
  logic        sign_q, sign_e_d;
  logic [31:0] res_q, res_d;

  logic start_acc;
  assign start_acc = (state_q == IDLE) && !busy_q && start;

  // ALIGN: classify, order by magnitude and align the smaller add operand
  logic [7:0]       ea, eb, diff;
  logic             za, zb;
  logic [30:0]      mag_a, mag_b;
  logic [31:0]      xa, ya;
  logic [SIG_W-1:0] sig_y, lost_mask, y_sig_al;

  always_comb begin
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    za    = (ea == 8'd0);
    zb    = (eb == 8'd0);
    mag_a = za ? 31'd0 : a_q[30:0];
    mag_b = zb ? 31'd0 : b_q[30:0];
    xa    = (mag_a >= mag_b) ? a_q : b_q;
    ya    = (mag_a >= mag_b) ? b_q : a_q;
    diff  = xa[30:23] - ya[30:23];
    sig_y = fpu_ext_sig(ya);
    lost_mask = (27'd1 << diff) - 27'd1;
    if (diff >= 8'd27) y_sig_al = {26'd0, |sig_y};
    else               y_sig_al = (sig_y >> diff) | {26'd0, |(sig_y & lost_mask)};

    if (op_q == FPU_OP_MUL) begin
      x_d = '{a_q[31], {2'b00, ea}, fpu_ext_sig(a_q)};
      y_d = '{b_q[31], {2'b00, eb}, fpu_ext_sig(b_q)};
    end else begin
      x_d = '{xa[31], {2'b00, xa[30:23]}, fpu_ext_sig(xa)};
      y_d = '{ya[31], {2'b00, ya[30:23]}, y_sig_al};
    end

    // Special operands and zero shortcuts bypass the arithmetic
    byp_d     = 1'b1;
    byp_val_d = '0;
    if (ea == FPU_EXP_MAX || eb == FPU_EXP_MAX) byp_val_d = FPU_QNAN;
    else if (op_q == FPU_OP_MUL && (za || zb))  byp_val_d = {a_q[31] ^ b_q[31], 31'd0};
    else if (op_q == FPU_OP_ADD && zb)          byp_val_d = za ? {a_q[31] & b_q[31], 31'd0} : a_q;
    else if (op_q == FPU_OP_ADD && za)          byp_val_d = b_q;
    else                                        byp_d     = 1'b0;
  end

  // EXEC: 28-bit add/sub or 24x24 multiply folded into the same format
  logic [47:0] prod;

  always_comb begin
    prod = 48'(x_q.sig[26:3]) * 48'(y_q.sig[26:3]);
    if (op_q == FPU_OP_MUL) begin
      sig_e_d  = {prod[47:21], |prod[20:0]};
      exp_e_d  = x_q.exp + y_q.exp - 10'(FPU_BIAS);
      sign_e_d = x_q.sign ^ y_q.sign;
    end else begin
      if (x_q.sign != y_q.sign) sig_e_d = {1'b0, x_q.sig} - {1'b0, y_q.sig};
      else                      sig_e_d = {1'b0, x_q.sig} + {1'b0, y_q.sig};
      exp_e_d  = x_q.exp;
      sign_e_d = x_q.sign;
    end
  end

  // NORM: normalize so bit 27 is the leading one; bit 26 weighs 2^exp
  logic [LZ_W-1:0]   lz;
  logic [NSIG_W-1:0] norm_sig;
  logic signed [EXP_W-1:0] exp_n, exp_f;
  logic [22:0] mant_f;

  fpu_norm u_norm (
    .sig_i  (sig_q),
    .lz_o   (lz),
    .norm_o (norm_sig)
  );

`ifdef FPU_ROUND_NEAREST_EN
  logic        rnd_up;
  logic [24:0] mant_r;
`else
  logic unused_ext;
  assign unused_ext = ^{norm_sig[27], norm_sig[3:0]};
`endif

  always_comb begin
    exp_n = $signed(exp_q) + 10'sd1 - $signed({5'd0, lz});
`ifdef FPU_ROUND_NEAREST_EN
    rnd_up = norm_sig[3] & (norm_sig[2] | (|norm_sig[1:0]) | norm_sig[4]);
    mant_r = {1'b0, norm_sig[27:4]} + 25'(rnd_up);
    if (mant_r[24]) begin
      mant_f = mant_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      mant_f = mant_r[22:0];
      exp_f  = exp_n;
    end
`else
    mant_f = norm_sig[26:4];
    exp_f  = exp_n;
`endif
    if (byp_q)                res_d = byp_val_q;
    else if (sig_q == '0)     res_d = 32'h0000_0000;
    else if (exp_f > 10'sd254) res_d = {sign_q, FPU_EXP_MAX, 23'd0};
    else if (exp_f < 10'sd1)  res_d = {sign_q, 31'd0};
    else                      res_d = {sign_q, exp_f[7:0], mant_f};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= 2'b00;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // busy still high here only during the done cycle
          if (busy_q) busy_q <= 1'b0;
          else if (start) begin
            state_q <= ALIGN;
            busy_q  <= 1'b1;
          end
        end
        ALIGN: state_q <= EXEC;
        EXEC:  state_q <= NORM;
        NORM:  state_q <= DONE;
        DONE: begin
          state_q  <= IDLE;
          done_q   <= 1'b1;
          result_q <= res_q;
          flags_q  <= {res_q[31], (res_q[30:0] == 31'd0)};
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath stage registers, loaded only in their own state
  always_ff @(posedge clk) begin
    if (start_acc) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
    if (state_q == ALIGN) begin
      x_q       <= x_d;
      y_q       <= y_d;
      byp_q     <= byp_d;
      byp_val_q <= byp_val_d;
    end
    if (state_q == EXEC) begin
      sig_q  <= sig_e_d;
      exp_q  <= exp_e_d;
      sign_q <= sign_e_d;
    end
    if (state_q == NORM) res_q <= res_d;
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign flags  = flags_q;

  // Every accepted start must surface as done exactly four edges later
  generate
    if (LAT_CHECK == 1) begin : g_lat_check
      logic [4:0] acc_sr_q;
      always_ff @(posedge clk) begin
        if (reset) acc_sr_q <= '0;
        else       acc_sr_q <= {acc_sr_q[3:0], start_acc};
      end
      always_ff @(posedge clk) begin
        if (!reset) assert (done_q == acc_sr_q[4]);
      end
    end
  endgenerate

endmodule

// File: tb/tb_fpu_unit.sv
// Self-checking bench for fpu_unit: scoreboard queue of expected results,
// one task per scenario, summary line at the end.
module tb_fpu_unit;

  logic        clk, reset, start, op;
  logic [31:0] a, b, result;
  logic        done, busy;
  logic [1:0]  flags;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  flg;
  } exp_t;

  exp_t sb_q[$];

  fpu_unit #(.LAT_CHECK(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [1:0] model_flags(input logic [31:0] r);
    return {r[31], (r[30:0] == 31'd0)};
  endfunction

  // Push expectation, then present a one-cycle start sampled at edge k
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic iop, input logic [31:0] er);
    sb_q.push_back('{er, model_flags(er)});
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n=0 is the cycle after edge k; done is expected at n=4
  task automatic wait_done(output int lat, output logic [15:0] busy_seen);
    lat = -1;
    busy_seen = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      busy_seen[n] = busy;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", flags); end
  endtask

  task automatic test_add_basic();
    int lat; logic [15:0] bs; exp_t e;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    wait_done(lat, bs);
    e = pop_exp();
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    checks++; if (bs[4:0] !== 5'b11111) begin errors++; $display("FAIL add_busy: got %b expected 11111", bs[4:0]); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL add_result: got %h expected %h", result, e.res); end
    checks++; if (flags !== e.flg) begin errors++; $display("FAIL add_flags: got %b expected %b", flags, e.flg); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_drop: got %b expected 0", busy); end
  endtask

  task automatic test_mul();
    int lat; logic [15:0] bs; exp_t e;
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    logic [31:0] tr [2];
    ta = '{32'h3FC00000, 32'hBF800000};
    tb = '{32'h40000000, 32'h40000000};
    tr = '{32'h40400000, 32'hC0000000};
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 1'b1, tr[i]);
      wait_done(lat, bs);
      e = pop_exp();
      checks++; if (lat !== 4) begin errors++; $display("FAIL mul%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL mul%0d_result: got %h expected %h", i, result, e.res); end
      checks++; if (flags !== e.flg) begin errors++; $display("FAIL mul%0d_flags: got %b expected %b", i, flags, e.flg); end
    end
  endtask

  task automatic test_cancel();
    int lat; logic [15:0] bs; exp_t e;
    issue(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000);
    wait_done(lat, bs);
    e = pop_exp();
    checks++; if (result !== e.res) begin errors++; $display("FAIL cancel_result: got %h expected %h", result, e.res); end
    checks++; if (flags !== 2'b01) begin errors++; $display("FAIL cancel_flags: got %b expected 01", flags); end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
  } vec_t;

  task automatic test_specials();
    int lat; logic [15:0] bs; exp_t e;
    vec_t vt [12];
    vt = '{
      '{32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000},  // mul overflow
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000},  // NaN add
      '{32'h7FC00001, 32'h40000000, 1'b1, 32'h7FC00000},  // NaN mul
      '{32'h00000001, 32'h3F800000, 1'b1, 32'h00000000},  // subnormal flush
      '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB},  // add zero
      '{32'h80000000, 32'h3F800000, 1'b1, 32'h80000000},  // signed zero mul
      '{32'h80800000, 32'h3F000000, 1'b1, 32'h80000000},  // mul underflow
      '{32'hFF800000, 32'h3F800000, 1'b0, 32'h7FC00000},  // Inf operand
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000},  // add overflow
      '{32'h3FC00000, 32'hBFA00000, 1'b0, 32'h3E800000},  // left normalize
      '{32'h3F800000, 32'hC0400000, 1'b0, 32'hC0000000},  // swap, sign of b
      '{32'h3F800000, 32'h2B800000, 1'b0, 32'h3F800000}   // diff >= 27
    };
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].op, vt[i].r);
      wait_done(lat, bs);
      e = pop_exp();
      checks++; if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL vec%0d_result: got %h expected %h", i, result, e.res); end
      checks++; if (flags !== e.flg) begin errors++; $display("FAIL vec%0d_flags: got %b expected %b", i, flags, e.flg); end
    end
  endtask

  task automatic test_rounding();
    int lat; logic [15:0] bs; exp_t e;
`ifdef FPU_ROUND_NEAREST_EN
    issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001);
`else
    issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000);
`endif
    wait_done(lat, bs);
    e = pop_exp();
    checks++; if (result !== e.res) begin errors++; $display("FAIL round_result: got %h expected %h", result, e.res); end
  endtask

  task automatic test_back_to_back();
    int lat; int extra; logic [15:0] bs; exp_t e;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    @(posedge clk);
    #1 a = 32'h41200000; b = 32'h41200000; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bs);
    e = pop_exp();
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_result: got %h expected %h", result, e.res); end
    // start during the done cycle must also be dropped
    a = 32'h41200000; b = 32'h41200000; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_done: got %0d expected 0", extra); end
    issue(32'h40000000, 32'h40000000, 1'b1, 32'h40800000);
    wait_done(lat, bs);
    e = pop_exp();
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_next_latency: got %0d expected 4", lat); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_next_result: got %h expected %h", result, e.res); end
  endtask

  task automatic test_reset_mid();
    int lat; int extra; logic [15:0] bs; exp_t e;
    issue(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 00000000", result); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b expected 00", flags); end
    extra = 0;
    for (int n = 0; n < 8; n++) begin
      if (done) extra++;
      @(negedge clk);
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", extra); end
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    wait_done(lat, bs);
    e = pop_exp();
    checks++; if (lat !== 4) begin errors++; $display("FAIL after_abort_latency: got %0d expected 4", lat); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL after_abort_result: got %h expected %h", result, e.res); end
    checks++; if (flags !== e.flg) begin errors++; $display("FAIL after_abort_flags: got %b expected %b", flags, e.flg); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_basic();
    test_mul();
    test_cancel();
    test_specials();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
